// File: rtl/de_i2c_pkg.sv
// Shared types and constants for the DE-board I2C register target.
package de_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_SUB      = 4'd3,
        ST_SUB_ACK  = 4'd4,
        ST_DATA     = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_RD       = 4'd7,
        ST_RD_ACK   = 4'd8
    } i2c_slv_st_t;

    localparam logic       RW_WRITE    = 1'b0;
    localparam logic       RW_READ     = 1'b1;
    localparam logic [3:0] BYTE_BITS   = 4'd8;
    localparam logic [3:0] ACK_BIT_IDX = 4'd8;

    // True when the sub-address pointer addresses a real storage register.
    function automatic logic ptr_in_range(input logic [7:0] ptr, input int unsigned depth);
        return ({24'd0, ptr} < depth);
    endfunction

endpackage

// File: rtl/de_i2c_bus_sync.sv
// SCL/SDA synchronizers with edge history; decodes SCL edges and START/STOP pulses.
module de_i2c_bus_sync (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0] metastability flop, [1] synced value, [2] previous synced value
    logic [2:0] r_scl_pipe;
    logic [2:0] r_sda_pipe;

    // Two-flop synchronizer plus one history flop per line; idle bus is high.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_scl_pipe <= 3'b111;
            r_sda_pipe <= 3'b111;
        end else begin
            r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
            r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
        end
    end

    assign o_sda      = r_sda_pipe[1];
    assign o_scl_rise = r_scl_pipe[1] & ~r_scl_pipe[2];
    assign o_scl_fall = ~r_scl_pipe[1] & r_scl_pipe[2];
    assign o_start    = r_scl_pipe[1] & r_scl_pipe[2] & r_sda_pipe[2] & ~r_sda_pipe[1];
    assign o_stop     = r_scl_pipe[1] & r_scl_pipe[2] & ~r_sda_pipe[2] & r_sda_pipe[1];

endmodule

// File: rtl/de_i2c_reg_slave.sv
// I2C target decoding [SLAVE_ADDR, SUB_ADDR, DATA...] write frames into a register bank.
// Define I2C_SLAVE_READ_EN to also serve read frames from the register bank.
module de_i2c_reg_slave
    import de_i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
    parameter int unsigned REG_DEPTH  = 64
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR_STB,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oBUSY
);

    localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    de_i2c_bus_sync u_sync (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .i_scl      (I2C_SCLK),
        .i_sda      (I2C_SDAT),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_slv_st_t r_st, w_st_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [7:0]  r_ptr, w_ptr_nxt;
    logic        r_sda_low, w_sda_low_nxt;
    logic        r_stb, w_stb_nxt;
    logic [7:0]  r_wr_addr, w_wr_addr_nxt;
    logic [7:0]  r_wr_data, w_wr_data_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_reg_we;
    logic [7:0]  r_regs [REG_DEPTH];

    assign I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;
    assign oWR_STB  = r_stb;
    assign oWR_ADDR = r_wr_addr;
    assign oWR_DATA = r_wr_data;
    assign oBUSY    = r_busy;

`ifdef I2C_SLAVE_READ_EN
    logic [7:0] w_rd_ptr;
    logic [7:0] w_rd_byte;

    // RD_ACK preloads the byte after the current pointer for the next read.
    assign w_rd_ptr  = (r_st == ST_RD_ACK) ? (r_ptr + 8'd1) : r_ptr;
    assign w_rd_byte = ptr_in_range(w_rd_ptr, REG_DEPTH) ? r_regs[w_rd_ptr[AW-1:0]] : 8'hFF;
`endif

    // Next-state, shift/pointer and output decode; bus START/STOP override everything.
    always_comb begin
        w_st_nxt      = r_st;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_low_nxt = r_sda_low;
        w_stb_nxt     = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = r_busy;
        w_reg_we      = 1'b0;
        if (w_start) begin
            w_st_nxt      = ST_ADDR;
            w_cnt_nxt     = 4'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b1;
        end else if (w_stop) begin
            w_st_nxt      = ST_IDLE;
            w_cnt_nxt     = 4'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_st)
                ST_ADDR, ST_SUB, ST_DATA: begin
                    if (w_scl_rise && (r_cnt < BYTE_BITS)) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall && (r_cnt == ACK_BIT_IDX)) begin
                        w_cnt_nxt     = 4'd0;
                        w_sda_low_nxt = 1'b1;
                        case (r_st)
                            ST_ADDR: begin
                                if (r_shift == {SLAVE_ADDR, RW_WRITE}) begin
                                    w_st_nxt = ST_ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
                                end else if (r_shift == {SLAVE_ADDR, RW_READ}) begin
                                    w_st_nxt = ST_ADDR_ACK;
`endif
                                end else begin
                                    w_st_nxt      = ST_IDLE;
                                    w_sda_low_nxt = 1'b0;
                                end
                            end
                            ST_SUB: begin
                                w_st_nxt  = ST_SUB_ACK;
                                w_ptr_nxt = r_shift;
                            end
                            default: w_st_nxt = ST_DATA_ACK;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_st_nxt      = ST_SUB;
`ifdef I2C_SLAVE_READ_EN
                        if (r_shift[0] == RW_READ) begin
                            w_st_nxt      = ST_RD;
                            w_shift_nxt   = w_rd_byte;
                            w_sda_low_nxt = ~w_rd_byte[7];
                        end else begin
                            w_st_nxt = ST_SUB;
                        end
`endif
                    end else begin
                        w_st_nxt = r_st;
                    end
                end
                ST_SUB_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_st_nxt      = ST_DATA;
                    end else begin
                        w_st_nxt = r_st;
                    end
                end
                ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_st_nxt      = ST_DATA;
                        w_stb_nxt     = 1'b1;
                        w_wr_addr_nxt = r_ptr;
                        w_wr_data_nxt = r_shift;
                        w_reg_we      = ptr_in_range(r_ptr, REG_DEPTH);
                        w_ptr_nxt     = r_ptr + 8'd1;
                    end else begin
                        w_st_nxt = r_st;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                ST_RD: begin
                    if (w_scl_rise && (r_cnt < BYTE_BITS)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall && (r_cnt == ACK_BIT_IDX)) begin
                        w_cnt_nxt     = 4'd0;
                        w_sda_low_nxt = 1'b0;
                        w_st_nxt      = ST_RD_ACK;
                    end else if (w_scl_fall) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_sda_low_nxt = ~r_shift[6];
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_RD_ACK: begin
                    // The master's ACK bit is parked in shift[0] until the falling edge.
                    if (w_scl_rise) begin
                        w_shift_nxt = {7'd0, w_sda};
                    end else if (w_scl_fall) begin
                        w_ptr_nxt = r_ptr + 8'd1;
                        if (r_shift[0] == 1'b0) begin
                            w_st_nxt      = ST_RD;
                            w_shift_nxt   = w_rd_byte;
                            w_sda_low_nxt = ~w_rd_byte[7];
                        end else begin
                            w_st_nxt = ST_IDLE;
                        end
                    end else begin
                        w_st_nxt = r_st;
                    end
                end
`endif
                default: w_st_nxt = ST_IDLE;
            endcase
        end
    end

    // Control and output registers; reset releases SDA asynchronously.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_st      <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= 8'd0;
            r_sda_low <= 1'b0;
            r_stb     <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            r_st      <= w_st_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_stb     <= w_stb_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Register bank, written together with the data strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < int'(REG_DEPTH); i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_reg_we) begin
            r_regs[r_ptr[AW-1:0]] <= r_shift;
        end
    end

endmodule

// File: tb/tb_de_i2c_reg_slave.sv
// Directed bench for de_i2c_reg_slave: bit-banged I2C master with immediate-assert checks.
module tb_de_i2c_reg_slave;
    import de_i2c_pkg::*;

    localparam int Q = 8;  // quarter SCL period in iCLK cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic tb_sda_low = 1'b0;
    wire  sda_bus;
    logic       stb;
    logic [7:0] wr_addr, wr_data;
    logic       busy;

    assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    de_i2c_reg_slave dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .oWR_STB  (stb),
        .oWR_ADDR (wr_addr),
        .oWR_DATA (wr_data),
        .oBUSY    (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int drove_cnt = 0;
    logic [7:0] stb_addr [32];
    logic [7:0] stb_data [32];

    always @(negedge clk) begin
        if (stb === 1'b1) begin
            stb_addr[stb_cnt[4:0]] = wr_addr;
            stb_data[stb_cnt[4:0]] = wr_data;
            stb_cnt = stb_cnt + 1;
        end
        if (!tb_sda_low && sda_bus === 1'b0) drove_cnt = drove_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic tx, output logic rx);
        tb_sda_low = ~tx;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        rx = sda_bus;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        tb_sda_low = 1'b1;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        tb_sda_low = 1'b0;
        cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) bit_io(b[i], rx);
        bit_io(1'b1, rx);
        ack = (rx === 1'b0);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        logic rx;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, rx);
            b[i] = rx;
        end
        bit_io(~master_ack, rx);
    endtask

    initial begin
        logic a0, a1, a2, a3, a4;
        logic rx;
        int s0, d0;
        logic [7:0] rb;

        // Reset state
        cyc(3);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        rst_n = 1'b1;
        cyc(4);

        // Single write 34,0C,00 with oBUSY fall timing
        s0 = stb_cnt;
        i2c_start();
        chk("w1_busy", 32'(busy), 32'd1);
        send_byte(8'h34, a0);
        send_byte(8'h0C, a1);
        send_byte(8'h00, a2);
        chk("w1_acks", {29'd0, a0, a1, a2}, 32'h7);
        tb_sda_low = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        tb_sda_low = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("w1_busy_hold", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("w1_busy_fall", 32'(busy), 32'd0);
        cyc(Q);
        chk("w1_nstb", stb_cnt - s0, 32'd1);
        chk("w1_saddr", 32'(stb_addr[s0[4:0]]), 32'h0C);
        chk("w1_sdata", 32'(stb_data[s0[4:0]]), 32'h00);
        chk("w1_reg12", 32'(dut.r_regs[12]), 32'h00);

        // Wrong address: NACK, SDA never driven, no strobe
        s0 = stb_cnt;
        d0 = drove_cnt;
        i2c_start();
        send_byte(8'h40, a0);
        send_byte(8'h12, a1);
        send_byte(8'h34, a2);
        i2c_stop();
        chk("nak_ack", {29'd0, a0, a1, a2}, 32'h0);
        chk("nak_drive", drove_cnt - d0, 32'd0);
        chk("nak_nstb", stb_cnt - s0, 32'd0);

        // Burst crossing the end of the register bank
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h3E, a1);
        send_byte(8'hA1, a2);
        send_byte(8'hA2, a3);
        send_byte(8'hA3, a4);
        i2c_stop();
        chk("bur_acks", {27'd0, a0, a1, a2, a3, a4}, 32'h1F);
        chk("bur_nstb", stb_cnt - s0, 32'd3);
        chk("bur_a0", {stb_addr[s0[4:0]], stb_data[s0[4:0]]}, 32'h3EA1);
        chk("bur_a1", {stb_addr[5'(s0 + 1)], stb_data[5'(s0 + 1)]}, 32'h3FA2);
        chk("bur_a2", {stb_addr[5'(s0 + 2)], stb_data[5'(s0 + 2)]}, 32'h40A3);
        chk("bur_reg62", 32'(dut.r_regs[62]), 32'hA1);
        chk("bur_reg63", 32'(dut.r_regs[63]), 32'hA2);
        chk("bur_ptr", 32'(dut.r_ptr), 32'h41);

        // STOP after 4 data bits: discarded, pointer unchanged
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h10, a1);
        for (int i = 0; i < 4; i++) bit_io(1'b1, rx);
        i2c_stop();
        chk("part_nstb", stb_cnt - s0, 32'd0);
        chk("part_ptr", 32'(dut.r_ptr), 32'h10);
        chk("part_state", 32'(dut.r_st), 32'(ST_IDLE));
        chk("part_busy", 32'(busy), 32'd0);

        // Pointer wrap FF->00: FF strobed not stored, 00 stored
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        i2c_stop();
        chk("wrap_nstb", stb_cnt - s0, 32'd2);
        chk("wrap_a0", {stb_addr[s0[4:0]], stb_data[s0[4:0]]}, 32'hFF11);
        chk("wrap_a1", {stb_addr[5'(s0 + 1)], stb_data[5'(s0 + 1)]}, 32'h0022);
        chk("wrap_reg0", 32'(dut.r_regs[0]), 32'h22);

`ifdef I2C_SLAVE_READ_EN
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h05, a0);
        send_byte(8'h5A, a0);
        send_byte(8'hC3, a0);
        i2c_stop();
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h05, a1);
        i2c_start();
        send_byte(8'h35, a2);
        chk("rd_acks", {29'd0, a0, a1, a2}, 32'h7);
        recv_byte(1'b1, rb);
        chk("rd_byte0", 32'(rb), 32'h5A);
        recv_byte(1'b0, rb);
        chk("rd_byte1", 32'(rb), 32'hC3);
        i2c_stop();
        chk("rd_ptr", 32'(dut.r_ptr), 32'h07);
        chk("rd_nstb", stb_cnt - s0, 32'd0);
`else
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h05, a1);
        i2c_start();
        send_byte(8'h35, a2);
        i2c_stop();
        chk("rd_acks", {29'd0, a0, a1, a2}, 32'h6);
        chk("rd_nstb", stb_cnt - s0, 32'd0);
`endif

        // Reset asserted while the address ACK is driven
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_io(logic'((8'h34 >> i) & 8'h01), rx);
        tb_sda_low = 1'b0;
        cyc(1);
        chk("ra_sda_ack", 32'(sda_bus), 32'd0);
        chk("ra_state", 32'(dut.r_st), 32'(ST_ADDR_ACK));
        rst_n = 1'b0;
        #1;
        chk("ra_sda_rel", 32'(sda_bus), 32'd1);
        chk("ra_idle", 32'(dut.r_st), 32'(ST_IDLE));
        chk("ra_busy", 32'(busy), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        i2c_stop();
        chk("ra_after", 32'(dut.r_st), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
